lane_jam_sensor: RTL
====================

// Module: lane_jam_sensor
// PURPOSE
//   Road-side model feeding traffic_system_top. It receives the allow_0..3 grants and
//   produces the jam_sensor_0..3 inputs.
//   - One vehicle queue per lane. Arrival pulses raise the count.
//   - A granted lane drains one car every DRAIN_CYCLES cycles.
//   - jam_sensor_x is the queue level passed through a hysteresis comparator.
//   - Closes the loop around the controller in system benches; also usable as a
//     synthesizable sensor front end.
// PARAMETERS
//   CNT_W         6   queue counter width
//   MAX_Q         40  queue saturation level; must satisfy MAX_Q < 2**CNT_W
//   JAM_ON        8   jam asserts at count >= JAM_ON; must satisfy JAM_ON <= MAX_Q
//   JAM_OFF       3   jam clears at count <= JAM_OFF; must satisfy JAM_OFF < JAM_ON
//   DRAIN_CYCLES  2   cycles of continuous allow per departure; must be >= 1
// PORTS
//   clk           in   1      system clock; all state updates on the rising edge
//   rst           in   1      asynchronous, active-high reset
//   car_arrive    in   4      bit i = one car arrives at lane i this cycle
//   allow_0..3    in   1 ea   green grant per lane, from traffic_system_top
//   jam_sensor_0..3 out 1 ea  registered jam flag per lane, to traffic_system_top
//   q_len_0..3    out  CNT_W  registered queue count per lane
//   overflow      out  4      sticky drop flag per lane; present only with JAM_SENSOR_OVF_EN
// BEHAVIOUR
//   Reset (async, while rst=1): every q_len=0, every jam_sensor=0, every drain counter=0,
//     overflow=0. Outputs go low immediately, not at the next edge.
//     Reset mid-operation discards all queue contents.
//   Per lane i, drain counter dcnt_i (width clog2(DRAIN_CYCLES), minimum 1 bit):
//     - allow_i=0: dcnt_i <= 0.
//     - allow_i=1: dcnt_i increments; wraps to 0 after DRAIN_CYCLES-1.
//   depart_i = allow_i & (dcnt_i == DRAIN_CYCLES-1) & (q_len_i != 0).
//     - A departure tick with an empty queue is lost; dcnt_i still wraps.
//     - DRAIN_CYCLES=1: one departure every allowed cycle.
//   Queue update, one edge (arrival and departure both sampled on the same edge):
//     - arrive & depart: count unchanged.
//     - arrive only, count < MAX_Q: count + 1.
//     - arrive only, count == MAX_Q: count holds; the arrival is dropped.
//     - depart only: count - 1.
//     - neither: hold.
//   Jam hysteresis, evaluated on the next count q_nx (same edge as q_len):
//     - q_nx >= JAM_ON: jam <= 1.
//     - q_nx <= JAM_OFF: jam <= 0.
//     - otherwise: jam holds.
//   Latency: an arrival sampled at edge k is visible on q_len and jam_sensor right
//     after edge k. Departures have the same latency.
//   The four lanes are fully independent. allow inputs are not checked for mutual
//     exclusion; several lanes may drain at once.
//   All arithmetic is unsigned CNT_W. The count never wraps below 0 or above MAX_Q.
// CONFIGURATION
//   JAM_SENSOR_OVF_EN defined:
//     - overflow[3:0] port exists.
//     - overflow[i] <= 1 on any edge where lane i is at MAX_Q, arrives, and does not
//       depart.
//     - Cleared only by rst.
//   JAM_SENSOR_OVF_EN undefined:
//     - Port and flops are absent.
//     - Dropped arrivals are silent; all other behaviour is identical.
// TESTING (defaults; DRAIN_CYCLES=2)
//   1. Pulse car_arrive[1] 7 times with allow_1=0
//      -> q_len_1=7, jam_sensor_1=0. 8th pulse -> q_len_1=8, jam_sensor_1=1 right after
//      that edge.
//   2. Lane2 at 8 with jam=1, then hold allow_2=1
//      -> count steps 7,6,5,4 every 2 cycles with jam_sensor_2 still 1.
//      -> jam_sensor_2=0 on the edge where the count reaches 3 (10th allowed cycle).
//      -> Drains to 0 and stays there; no underflow.
//   3. Lane0 at 5 with allow_0=1; assert car_arrive[0] on each departure cycle
//      -> q_len_0 stays 5; jam_sensor_0 is unchanged.
//   4. Drop allow_3 for 1 cycle after 1 allowed cycle, then reassert
//      -> next departure comes 2 full allowed cycles after the reassert
//         (dcnt_3 was cleared).
//   5. 45 arrivals on lane3 with allow_3=0
//      -> q_len_3 saturates at 40; jam_sensor_3=1.
//      -> With JAM_SENSOR_OVF_EN: overflow=4'b1000, still 1 after lane 3 drains.
//   6. Lane1 at 12, assert rst asynchronously mid-cycle
//      -> q_len_1=0 and jam_sensor_1=0 before the next clk edge.
//      -> After release, one arrival gives q_len_1=1.

Source files
------------

// File: rtl/lane_jam_sensor.sv
// Four-lane vehicle queue model: arrivals raise each count, granted lanes drain one car per
// DRAIN_CYCLES, jam flags use hysteresis. Define JAM_SENSOR_OVF_EN for sticky drop flags.
module lane_jam_sensor #(
   parameter int unsigned CNT_W        = 6,
   parameter int unsigned MAX_Q        = 40,
   parameter int unsigned JAM_ON       = 8,
   parameter int unsigned JAM_OFF      = 3,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       car_arrive,
   input  logic             allow_0,
   input  logic             allow_1,
   input  logic             allow_2,
   input  logic             allow_3,
   output logic             jam_sensor_0,
   output logic             jam_sensor_1,
   output logic             jam_sensor_2,
   output logic             jam_sensor_3,
   output logic [CNT_W-1:0] q_len_0,
   output logic [CNT_W-1:0] q_len_1,
   output logic [CNT_W-1:0] q_len_2,
   output logic [CNT_W-1:0] q_len_3
`ifdef JAM_SENSOR_OVF_EN
   ,
   output logic [3:0]       overflow
`endif
);

   localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  MaxQ     = CNT_W'(MAX_Q);
   localparam logic [CNT_W-1:0]  JamOn    = CNT_W'(JAM_ON);
   localparam logic [CNT_W-1:0]  JamOff   = CNT_W'(JAM_OFF);
   localparam logic [DCNT_W-1:0] DcntLast = DCNT_W'(DRAIN_CYCLES - 1);

   logic [3:0]        allow;
   logic [3:0]        depart;
   logic [CNT_W-1:0]  q_len_q [4];
   logic [CNT_W-1:0]  q_len_d [4];
   logic [DCNT_W-1:0] dcnt_q  [4];
   logic [DCNT_W-1:0] dcnt_d  [4];
   logic [3:0]        jam_q;
   logic [3:0]        jam_d;

   assign allow = {allow_3, allow_2, allow_1, allow_0};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dcnt_d[i]  = '0;
         depart[i]  = 1'b0;
         q_len_d[i] = q_len_q[i];
         jam_d[i]   = jam_q[i];

         if (allow[i]) begin
            dcnt_d[i] = (dcnt_q[i] == DcntLast) ? '0 : dcnt_q[i] + 1'b1;
         end
         // A drain tick on an empty queue is lost; the counter still wraps.
         depart[i] = allow[i] && (dcnt_q[i] == DcntLast) && (q_len_q[i] != '0);

         if (car_arrive[i] && !depart[i]) begin
            if (q_len_q[i] != MaxQ) begin
               q_len_d[i] = q_len_q[i] + 1'b1;
            end
         end else if (!car_arrive[i] && depart[i]) begin
            q_len_d[i] = q_len_q[i] - 1'b1;
         end

         if (q_len_d[i] >= JamOn) begin
            jam_d[i] = 1'b1;
         end else if (q_len_d[i] <= JamOff) begin
            jam_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            q_len_q[i] <= '0;
            dcnt_q[i]  <= '0;
         end
         jam_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            q_len_q[i] <= q_len_d[i];
            dcnt_q[i]  <= dcnt_d[i];
         end
         jam_q <= jam_d;
      end
   end

`ifdef JAM_SENSOR_OVF_EN
   logic [3:0] overflow_q;
   logic [3:0] overflow_d;

   always_comb begin
      overflow_d = overflow_q;
      for (int i = 0; i < 4; i++) begin
         if (car_arrive[i] && !depart[i] && (q_len_q[i] == MaxQ)) begin
            overflow_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= '0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`endif

   assign q_len_0      = q_len_q[0];
   assign q_len_1      = q_len_q[1];
   assign q_len_2      = q_len_q[2];
   assign q_len_3      = q_len_q[3];
   assign jam_sensor_0 = jam_q[0];
   assign jam_sensor_1 = jam_q[1];
   assign jam_sensor_2 = jam_q[2];
   assign jam_sensor_3 = jam_q[3];

endmodule
